alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing front-end that sits between the MISC-V datapath control and the clocked 16-bit ALU. Accepts one operation per valid/ready handshake, drives the ALU operand and opcode ports and holds them stable for the ALU's pipeline latency. Captures the ALU result and returns it with a zero flag over a valid/ready response channel. Also synthesizes a signed set-less-than on the ALU's unused opcode 5.

## Interface
- ALU_LATENCY, 1, cycles from stable ALU inputs to valid OutputData; legal 0..7
- WIDTH, 16, datapath width; fixed at 16 for MISC-V
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- ReqValid  in  1  request valid
- ReqReady  out  1  request accepted when ReqValid && ReqReady at a rising edge
- ReqOp  in  3  0 NOP, 1 ADD, 2 SUB, 3 OR, 4 AND, 5 SLT, 6 SHL, 7 SHR
- ReqA / ReqB  in  16  operands, signed two's complement
- FirstInput / SecondInput  out  16  to ALU
- ALUOp  out  3  to ALU
- OutputData  in  16  from ALU
- RespValid  out  1  response valid
- RespReady  in  1  response consumed when RespValid && RespReady
- RespData  out  16  result
- RespZero  out  1  RespData == 0
- RespIllegal  out  1  op 5 requested with compare support compiled out

## Operation
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: ReqReady=1. On accept, latch ReqA/ReqB/ReqOp into operand registers, load latency counter with ALU_LATENCY, go EXEC.
- EXEC: FirstInput/SecondInput/ALUOp driven from registers, held constant. Counter decrements each cycle. At counter==0, capture OutputData, go RESP.
- RESP: RespValid=1, RespData/RespZero/RespIllegal held stable until handshake, then IDLE.
- ALUOp mapping: ops 0–4, 6, 7 pass through. Op 5 issues ALUOp=2 (SUB).
- SLT result: 16'd1 if (diff[15] XOR ovf) else 0, where ovf = (A[15] != B[15]) && (diff[15] != A[15]).
- Shift semantics, including negative shift amounts, are owned by the ALU. The controller passes them unchanged.
- NOP is issued like any op. The ALU returns 0, giving RespZero=1.
- RespZero is computed from the final RespData, after SLT fix-up.
- Outside EXEC: ALUOp=0, operand outputs hold last values.

## Timing
- Reset values: ReqReady=1 (once Reset_n deasserts), RespValid=0, RespData=0, RespZero=0, RespIllegal=0, FirstInput=0, SecondInput=0, ALUOp=0, state IDLE, counter 0.
- Accept at edge k puts ALU inputs valid from k+1. Capture at edge k+1+ALU_LATENCY, with RespValid high immediately after.
- ALU_LATENCY=0: EXEC lasts one cycle and OutputData is sampled at edge k+1.
- Response handshake at edge m: ReqReady high from m. Earliest next accept is at edge m+1 (no overlap).
- Throughput: one op per ALU_LATENCY+3 cycles when RespReady is held high.
- ReqValid during EXEC/RESP is ignored. The requester must hold it.
- Reset_n low at any point, including mid-EXEC or mid-RESP: immediate return to reset values. The pending result is discarded and no response is emitted.

## Configuration
- ALU_ISSUE_SLT_EN defined: op 5 performs signed SLT as above, and RespIllegal is always 0.
- ALU_ISSUE_SLT_EN undefined: op 5 issues ALUOp=0. Response carries RespData=0, RespZero=1, RespIllegal=1, with timing identical to other ops.

## Structure
- Package alu_issue_pkg holds:
  - localparams OP_NOP..OP_SHR (3-bit)
  - state encoding ST_IDLE/ST_EXEC/ST_RESP
  - WIDTH constant
- One sub-module, alu_slt_fixup: combinational A, B, diff -> 16-bit SLT result. Instantiated only under ALU_ISSUE_SLT_EN.

## Test plan
- ADD A=15, B=28, ALU_LATENCY=1, accept at edge k -> RespValid at k+2, RespData=43, RespZero=0.
- SUB A=1, B=1 -> RespData=0, RespZero=1. SUB A=-3, B=-5 -> RespData=2.
- With SLT enabled:
  - SLT A=-13, B=4 -> RespData=1.
  - SLT A=16'h7FFF, B=16'h8000 (overflow case) -> RespData=0, RespZero=1.
- Backpressure: AND A=-15, B=3 with RespReady low 5 cycles -> RespValid and RespData=1 stable all 5 cycles, ReqReady=0. Next accept on the cycle after the handshake.
- Reset_n pulsed low during EXEC of OR A=1, B=2 -> all outputs return to reset values within the pulse, no RespValid afterwards. A new ADD 1+1 then returns 2.
- Op 5 with ALU_ISSUE_SLT_EN undefined -> ALUOp observed 0, RespIllegal=1, RespData=0, RespZero=1.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, FSM state encoding and datapath width shared by the ALU issue controller.
package alu_issue_pkg;
  localparam int WIDTH = 16;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_slt_fixup.sv
// alu_slt_fixup: turns the ALU's A-B difference into a signed set-less-than result.
module alu_slt_fixup
  import alu_issue_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] result
);
  logic ovf;
  always_comb begin
    ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    result = WIDTH'(diff[WIDTH-1] ^ ovf);
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front-end that issues one op to the clocked ALU and returns its result.
// Define ALU_ISSUE_SLT_EN to implement signed SLT on op 5; otherwise op 5 is flagged illegal.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [2:0]       ReqOp,
  input  logic [WIDTH-1:0] ReqA,
  input  logic [WIDTH-1:0] ReqB,
  output logic [WIDTH-1:0] FirstInput,
  output logic [WIDTH-1:0] SecondInput,
  output logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] OutputData,
  output logic             RespValid,
  input  logic             RespReady,
  output logic [WIDTH-1:0] RespData,
  output logic             RespZero,
  output logic             RespIllegal
);
  state_t state, state_d;
  logic [2:0] cnt, op_q, issue_op;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic accept, capture, illegal;
`ifdef ALU_ISSUE_SLT_EN
  logic [WIDTH-1:0] slt_res;
  alu_slt_fixup u_slt (.a(a_q), .b(b_q), .diff(OutputData), .result(slt_res));
  assign issue_op = (op_q == OP_SLT) ? OP_SUB : op_q;
  assign result   = (op_q == OP_SLT) ? slt_res : OutputData;
  assign illegal  = 1'b0;
`else
  assign issue_op = (op_q == OP_SLT) ? OP_NOP : op_q;
  assign result   = (op_q == OP_SLT) ? '0 : OutputData;
  assign illegal  = (op_q == OP_SLT);
`endif
  always_comb begin
    accept  = (state == ST_IDLE) && ReqValid;
    capture = (state == ST_EXEC) && (cnt == '0);
    state_d = accept ? ST_EXEC :
              capture ? ST_RESP :
              ((state == ST_RESP) && RespReady) ? ST_IDLE : state;
    ReqReady    = (state == ST_IDLE);
    RespValid   = (state == ST_RESP);
    ALUOp       = (state == ST_EXEC) ? issue_op : OP_NOP;
    FirstInput  = a_q;
    SecondInput = b_q;
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_NOP;
      RespData    <= '0;
      RespZero    <= 1'b0;
      RespIllegal <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q  <= ReqA;
        b_q  <= ReqB;
        op_q <= ReqOp;
        cnt  <= 3'(ALU_LATENCY);
      end else if ((state == ST_EXEC) && (cnt != '0)) begin
        cnt <= cnt - 3'd1;
      end
      if (capture) begin
        RespData    <= result;
        RespZero    <= (result == '0);
        RespIllegal <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a one-stage behavioural ALU.
module tb_alu_issue_ctrl;
  localparam int L = 1;
  typedef struct {
    logic [15:0] d;
    logic        z;
    logic        i;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1;
  logic resp_zero, resp_illegal;
  logic [2:0] req_op = '0, alu_op;
  logic [15:0] req_a = '0, req_b = '0, first_input, second_input, out_data, alu_q = '0, resp_data;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl #(.ALU_LATENCY(L)) dut (
    .CLK(clk), .Reset_n(rst_n), .ReqValid(req_valid), .ReqReady(req_ready),
    .ReqOp(req_op), .ReqA(req_a), .ReqB(req_b),
    .FirstInput(first_input), .SecondInput(second_input), .ALUOp(alu_op),
    .OutputData(out_data), .RespValid(resp_valid), .RespReady(resp_ready),
    .RespData(resp_data), .RespZero(resp_zero), .RespIllegal(resp_illegal)
  );
  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return 16'hDEAD;
      3'd6:    return a << b[3:0];
      3'd7:    return a >> b[3:0];
      default: return 16'h0000;
    endcase
  endfunction
  always @(posedge clk) alu_q <= alu_f(first_input, second_input, alu_op);
  assign out_data = alu_q;
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 16'(exp_q.size()), 16'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.d);
        check("resp_zero", 16'(resp_zero), 16'(e.z));
        check("resp_illegal", 16'(resp_illegal), 16'(e.i));
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] eop, input logic [15:0] ed, input logic ez, input logic ei,
                       input bit wait_resp);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 16'(req_ready), 16'd1);
    if (wait_resp) exp_q.push_back('{ed, ez, ei});
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("alu_op", 16'(alu_op), 16'(eop));
    check("first_input", first_input, a);
    check("second_input", second_input, b);
    if (wait_resp) begin
      n = 1;
      while (!resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("resp_latency", 16'(n), 16'(L + 2));
    end
  endtask
  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    check("idle_wait", 16'(req_ready), 16'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int hits;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 16'(resp_valid), 16'd0);
    check("rst_resp_data", resp_data, 16'd0);
    check("rst_resp_zero", 16'(resp_zero), 16'd0);
    check("rst_resp_illegal", 16'(resp_illegal), 16'd0);
    check("rst_first_input", first_input, 16'd0);
    check("rst_second_input", second_input, 16'd0);
    check("rst_alu_op", 16'(alu_op), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 16'(req_ready), 16'd1);
    issue(3'd1, 16'd15, 16'd28, 3'd1, 16'd43, 1'b0, 1'b0, 1'b1);
    issue(3'd2, 16'd1, 16'd1, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1);
    issue(3'd2, 16'hFFFD, 16'hFFFB, 3'd2, 16'd2, 1'b0, 1'b0, 1'b1);
    issue(3'd6, 16'd3, 16'd4, 3'd6, 16'd48, 1'b0, 1'b0, 1'b1);
    issue(3'd7, 16'h8000, 16'd15, 3'd7, 16'd1, 1'b0, 1'b0, 1'b1);
    issue(3'd0, 16'd9, 16'd9, 3'd0, 16'd0, 1'b1, 1'b0, 1'b1);
`ifdef ALU_ISSUE_SLT_EN
    issue(3'd5, 16'hFFF3, 16'd4, 3'd2, 16'd1, 1'b0, 1'b0, 1'b1);
    issue(3'd5, 16'h7FFF, 16'h8000, 3'd2, 16'd0, 1'b1, 1'b0, 1'b1);
`else
    issue(3'd5, 16'd7, 16'd3, 3'd0, 16'd0, 1'b1, 1'b1, 1'b1);
`endif
    wait_ready();
    resp_ready = 1'b0;
    issue(3'd4, 16'hFFF1, 16'd3, 3'd4, 16'd1, 1'b0, 1'b0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("bp_resp_valid", 16'(resp_valid), 16'd1);
      check("bp_resp_data", resp_data, 16'd1);
      check("bp_req_ready", 16'(req_ready), 16'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_req_ready", 16'(req_ready), 16'd1);
    check("post_hs_resp_valid", 16'(resp_valid), 16'd0);
    issue(3'd1, 16'd5, 16'd6, 3'd1, 16'd11, 1'b0, 1'b0, 1'b1);
    issue(3'd3, 16'd1, 16'd2, 3'd3, 16'd3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", 16'(resp_valid), 16'd0);
    check("mid_rst_alu_op", 16'(alu_op), 16'd0);
    check("mid_rst_first_input", first_input, 16'd0);
    check("mid_rst_second_input", second_input, 16'd0);
    check("mid_rst_resp_data", resp_data, 16'd0);
    check("mid_rst_resp_zero", 16'(resp_zero), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) hits++;
    end
    check("no_resp_after_reset", 16'(hits), 16'd0);
    issue(3'd1, 16'd1, 16'd1, 3'd1, 16'd2, 1'b0, 1'b0, 1'b1);
    hits = 0;
    while (exp_q.size() != 0 && hits < 50) begin
      @(negedge clk);
      hits++;
    end
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
